// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU request sequencer.
//  - ALU opcode encodings (0..9 defined, anything above OP_MAX is an error)
//  - seq_state_e : sequencer FSM states
//  - trk_entry_t : one slot of the in-flight tracking pipe
//  - op_err()    : request error classification (bad opcode / divide by zero)
package alu_seq_pkg;

  localparam logic [31:0] OP_ADD = 32'd0;
  localparam logic [31:0] OP_SUB = 32'd1;
  localparam logic [31:0] OP_MUL = 32'd2;
  localparam logic [31:0] OP_DIV = 32'd3;
  localparam logic [31:0] OP_AND = 32'd4;
  localparam logic [31:0] OP_OR  = 32'd5;
  localparam logic [31:0] OP_XOR = 32'd6;
  localparam logic [31:0] OP_NOT = 32'd7;
  localparam logic [31:0] OP_LSL = 32'd8;
  localparam logic [31:0] OP_LSR = 32'd9;
  localparam logic [31:0] OP_MAX = 32'd9;

  // Tag width carried by the tracking pipe; the sequencer's TAG_W defaults to it.
  localparam int TRK_TAG_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } seq_state_e;

  typedef struct packed {
    logic                 valid;
    logic [TRK_TAG_W-1:0] tag;
    logic                 err;
  } trk_entry_t;

  function automatic logic op_err(input logic [31:0] op, input logic [31:0] b);
    return (op > OP_MAX) || ((op == OP_DIV) && (b == 32'd0));
  endfunction

endpackage

// File: rtl/alu_rsp_fifo.sv
// Synchronous FIFO for captured ALU responses.
//  clk/rst    : clock, asynchronous active-high reset (empties the FIFO)
//  push/wdata : write an entry (ignored only if full with no simultaneous pop)
//  pop        : remove head (ignored when empty)
//  head       : current head entry (meaningful when count != 0)
//  count      : number of stored entries
module alu_rsp_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 8,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [W-1:0]     wdata,
  input  logic             pop,
  output logic [W-1:0]     head,
  output logic [CNT_W-1:0] count
);

  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop  = pop && (cnt_q != '0);
    do_push = push && ((cnt_q != FULL) || do_pop);
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    // Explicit wrap so non-power-of-two depths work.
    if (do_push) wr_d = (wr_q == LAST) ? '0 : wr_q + PTR_W'(1);
    if (do_pop)  rd_d = (rd_q == LAST) ? '0 : rd_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only visible through count.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata;
  end

  assign head  = mem_q[rd_q];
  assign count = cnt_q;

endmodule

// File: rtl/alu_req_sequencer.sv
// Requester-side front end for a registered 32-bit ALU.
//  clk, rst            : clock; asynchronous active-high reset
//  en, busy            : enable accepting requests / activity indicator
//  req_*               : tagged request port (valid/ready)
//  alu_a/alu_b/alu_op  : registered ALU operand/opcode drive
//  alu_c               : ALU result
//  rsp_*               : in-order response port (valid/ready) fed by a FIFO
// Each accepted op is tracked through a valid/tag/err shift pipe that lines up
// with the ALU latency; the entry leaving the pipe captures alu_c into the FIFO.
// A single outstanding counter (in flight + buffered) bounds issue so the FIFO
// can never overflow.
module alu_req_sequencer
  import alu_seq_pkg::*;
#(
  parameter int ALU_LAT   = 2,
  parameter int RSP_DEPTH = 4,
  parameter int TAG_W     = TRK_TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             busy,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [31:0]      req_op,
  input  logic [TAG_W-1:0] req_tag,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [31:0]      alu_op,
  input  logic [31:0]      alu_c,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err
);

  // Operands are registered at accept (E0), the ALU samples them at E1 and
  // c settles ALU_LAT edges later, so the capture edge is E0+ALU_LAT+2:
  // pipe slots 0..STAGES, the last one pushing on the following edge.
  localparam int STAGES = ALU_LAT + 1;
  localparam int CNT_W  = $clog2(RSP_DEPTH + 1);
  localparam int FW     = 32 + TAG_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RSP_DEPTH);

  seq_state_e       state_q, state_d;
  logic [31:0]      alu_a_q, alu_a_d, alu_b_q, alu_b_d, alu_op_q, alu_op_d;
  trk_entry_t       trk_q [STAGES:0];
  trk_entry_t       trk_d [STAGES:0];
  logic [CNT_W-1:0] out_q, out_d;

  logic             accept, pop, push;
  logic [FW-1:0]    push_data, head;
  logic [CNT_W-1:0] fifo_cnt;

  // Ready depends on registers only.
  assign req_ready = (state_q == RUN) && (out_q < DEPTH_C);
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (fifo_cnt != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign busy      = (state_q != IDLE) || (out_q != '0);

  // Error entries return zero data whatever the ALU produced.
  assign push      = trk_q[STAGES].valid;
  assign push_data = {trk_q[STAGES].err ? 32'd0 : alu_c, trk_q[STAGES].tag, trk_q[STAGES].err};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (en) state_d = RUN;
      RUN:     if (!en) state_d = DRAIN;
      DRAIN:   if (en) state_d = RUN;
               else if (out_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_op_d = alu_op_q;
    trk_d[0] = '0;
    if (accept) begin
      alu_a_d        = req_a;
      alu_b_d        = req_b;
      alu_op_d       = req_op;
      trk_d[0].valid = 1'b1;
      trk_d[0].tag   = req_tag;
      trk_d[0].err   = op_err(req_op, req_b);
    end
    for (int i = 1; i <= STAGES; i++) trk_d[i] = trk_q[i-1];

    case ({accept, pop})
      2'b10:   out_d = out_q + CNT_W'(1);
      2'b01:   out_d = out_q - CNT_W'(1);
      default: out_d = out_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= '0;
      out_q    <= '0;
      for (int i = 0; i <= STAGES; i++) trk_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      out_q    <= out_d;
      for (int i = 0; i <= STAGES; i++) trk_q[i] <= trk_d[i];
    end
  end

  alu_rsp_fifo #(.DEPTH(RSP_DEPTH), .W(FW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (push_data),
    .pop   (pop),
    .head  (head),
    .count (fifo_cnt)
  );

  assign alu_a  = alu_a_q;
  assign alu_b  = alu_b_q;
  assign alu_op = alu_op_q;
  // Outputs read zero while the FIFO is empty (including during reset).
  assign {rsp_data, rsp_tag, rsp_err} = rsp_valid ? head : '0;

endmodule

// File: tb/tb_alu_req_sequencer.sv
module tb_alu_req_sequencer;

  logic        clk = 1'b0;
  logic        rst, en, req_valid, rsp_ready;
  logic        busy, req_ready, rsp_valid, rsp_err;
  logic [31:0] req_a, req_b, req_op, alu_a, alu_b, alu_op, rsp_data;
  logic [3:0]  req_tag, rsp_tag;
  logic [31:0] alu_c = '0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_req_sequencer #(.ALU_LAT(2), .RSP_DEPTH(4), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .en(en), .busy(busy),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_tag(req_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_tag(rsp_tag), .rsp_err(rsp_err)
  );

  // Registered ALU model: input register samples at E1, two result stages,
  // so c is stable after E1+2.
  function automatic logic [31:0] alu_f(input logic [31:0] a, b, op);
    case (op)
      32'd0:   return a + b;
      32'd1:   return a - b;
      32'd2:   return a * b;
      32'd3:   return (b == 0) ? 32'hDEAD_BEEF : a / b;
      32'd4:   return a & b;
      32'd5:   return a | b;
      32'd6:   return a ^ b;
      32'd7:   return ~a;
      32'd8:   return a << b[4:0];
      32'd9:   return a >> b[4:0];
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  logic [31:0] ia = '0, ib = '0, iop = '0, p1 = '0;
  always @(posedge clk) begin
    ia    <= alu_a;
    ib    <= alu_b;
    iop   <= alu_op;
    p1    <= alu_f(ia, ib, iop);
    alu_c <= p1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Presents a request, waits (bounded) for ready, returns just after the accept edge.
  task automatic send(input logic [31:0] a, b, op, input logic [3:0] tag);
    int w;
    w = 0;
    req_a = a; req_b = b; req_op = op; req_tag = tag; req_valid = 1'b1;
    while (!req_ready && w < 40) begin step(); w++; end
    if (!req_ready) chk("send_timeout", 32'd0, 32'd1);
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_valid(input string nm, output int cyc);
    cyc = 0;
    while (!rsp_valid && cyc < 30) begin step(); cyc++; end
    if (!rsp_valid) chk({nm, "_timeout"}, 32'd0, 32'd1);
  endtask

  typedef struct {
    logic [31:0] a, b, op;
    logic [3:0]  tag;
    logic [31:0] data;
    logic        err;
  } vec_t;

  vec_t vecs[14];

  task automatic set_bp(input int i);
    req_a = 32'(i + 1); req_b = 32'd2; req_op = 32'd0; req_tag = 4'(i + 8);
  endtask

  initial begin
    int lat, acc, got;
    logic a_ok;
    logic [3:0]  tags[$];
    logic [31:0] datas[$];

    vecs[0]  = '{32'd7,         32'd5,    32'd0,  4'd3,  32'd12,      1'b0};
    vecs[1]  = '{32'hF0,        32'd4,    32'd1,  4'd1,  32'hEC,      1'b0};
    vecs[2]  = '{32'hF0,        32'd4,    32'd2,  4'd2,  32'h3C0,     1'b0};
    vecs[3]  = '{32'hF0,        32'd4,    32'd4,  4'd4,  32'h0,       1'b0};
    vecs[4]  = '{32'hF0,        32'd4,    32'd9,  4'd5,  32'hF,       1'b0};
    vecs[5]  = '{32'd9,         32'd0,    32'd3,  4'd6,  32'd0,       1'b1};
    vecs[6]  = '{32'd9,         32'd3,    32'd12, 4'd7,  32'd0,       1'b1};
    vecs[7]  = '{32'd9,         32'd3,    32'd3,  4'd8,  32'd3,       1'b0};
    vecs[8]  = '{32'hF0,        32'h0F,   32'd5,  4'd9,  32'hFF,      1'b0};
    vecs[9]  = '{32'hFF,        32'h0F,   32'd6,  4'd10, 32'hF0,      1'b0};
    vecs[10] = '{32'd1,         32'd4,    32'd8,  4'd11, 32'h10,      1'b0};
    vecs[11] = '{32'hFFFF_FFFF, 32'd1,    32'd0,  4'd12, 32'd0,       1'b0};
    vecs[12] = '{32'd5,         32'd0,    32'd10, 4'd13, 32'd0,       1'b1};
    vecs[13] = '{32'd5,         32'd0,    32'd9,  4'd15, 32'd5,       1'b0};

    rst = 1'b1; en = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_a = '0; req_b = '0; req_op = '0; req_tag = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_rsp_data", rsp_data, 0);
    rst = 1'b0;
    step();
    chk("idle_busy", busy, 0);
    chk("idle_ready", req_ready, 0);

    // Table of single ops, each through an empty FIFO.
    en = 1'b1; rsp_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].tag);
      chk($sformatf("v%0d_alu_a", i), alu_a, vecs[i].a);
      chk($sformatf("v%0d_alu_op", i), alu_op, vecs[i].op);
      wait_valid($sformatf("v%0d", i), lat);
      chk($sformatf("v%0d_latency", i), lat, 4);
      chk($sformatf("v%0d_data", i), rsp_data, vecs[i].data);
      chk($sformatf("v%0d_tag", i), rsp_tag, vecs[i].tag);
      chk($sformatf("v%0d_err", i), rsp_err, vecs[i].err);
      step();
      chk($sformatf("v%0d_popped", i), rsp_valid, 0);
    end

    // Streaming: back-to-back accepts, one result per cycle.
    for (int i = 0; i < 4; i++) begin
      req_a = 32'hF0; req_b = 32'd4; req_tag = 4'(4 + i); req_valid = 1'b1;
      case (i)
        0: req_op = 32'd1;
        1: req_op = 32'd2;
        2: req_op = 32'd4;
        default: req_op = 32'd9;
      endcase
      chk($sformatf("stream_rdy%0d", i), req_ready, 1);
      step();
    end
    req_valid = 1'b0;
    wait_valid("stream", lat);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("stream_vld%0d", i), rsp_valid, 1);
      chk($sformatf("stream_tag%0d", i), rsp_tag, 4 + i);
      case (i)
        0: chk("stream_data0", rsp_data, 32'hEC);
        1: chk("stream_data1", rsp_data, 32'h3C0);
        2: chk("stream_data2", rsp_data, 32'h0);
        default: chk("stream_data3", rsp_data, 32'hF);
      endcase
      step();
    end
    chk("stream_empty", rsp_valid, 0);

    // Backpressure: 6 offered, only 4 fit while responses are blocked.
    rsp_ready = 1'b0; acc = 0; got = 0;
    set_bp(0); req_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      a_ok = req_valid && req_ready;
      step();
      if (a_ok) begin acc++; if (acc < 6) set_bp(acc); else req_valid = 1'b0; end
    end
    chk("bp_accepted", acc, 4);
    chk("bp_ready_low", req_ready, 0);
    chk("bp_busy", busy, 1);
    rsp_ready = 1'b1;
    for (int c = 0; c < 40 && got < 6; c++) begin
      a_ok = req_valid && req_ready;
      if (rsp_valid) begin
        chk($sformatf("bp_tag%0d", got), rsp_tag, got + 8);
        chk($sformatf("bp_data%0d", got), rsp_data, got + 3);
        got++;
      end
      step();
      if (a_ok) begin acc++; if (acc < 6) set_bp(acc); else req_valid = 1'b0; end
    end
    req_valid = 1'b0;
    chk("bp_got", got, 6);
    chk("bp_acc_total", acc, 6);

    // Drain: en drops on the same edge as the third accept.
    rsp_ready = 1'b0;
    send(32'd1, 32'd1, 32'd0, 4'd1);
    send(32'd2, 32'd2, 32'd0, 4'd2);
    req_a = 32'd3; req_b = 32'd3; req_op = 32'd0; req_tag = 4'd3; req_valid = 1'b1;
    chk("drain_rdy_before", req_ready, 1);
    en = 1'b0;
    step();
    chk("drain_rdy_after", req_ready, 0);
    req_a = 32'd4; req_b = 32'd4; req_tag = 4'd4;
    acc = 0; got = 0; tags.delete(); datas.delete();
    for (int c = 0; c < 6; c++) begin
      if (req_ready) acc++;
      step();
    end
    chk("drain_busy_held", busy, 1);
    rsp_ready = 1'b1;
    for (int c = 0; c < 20 && got < 3; c++) begin
      if (req_ready) acc++;
      if (rsp_valid) begin
        tags.push_back(rsp_tag); datas.push_back(rsp_data); got++;
        if (got == 3) chk("drain_busy_at_last", busy, 1);
      end
      step();
    end
    req_valid = 1'b0;
    for (int c = 0; c < 5 && busy; c++) step();
    chk("drain_busy_end", busy, 0);
    chk("drain_got", got, 3);
    chk("drain_no_accept", acc, 0);
    for (int i = 0; i < got; i++) begin
      chk($sformatf("drain_tag%0d", i), tags[i], i + 1);
      chk($sformatf("drain_data%0d", i), datas[i], 2 * (i + 1));
    end

    // Reset with one buffered and two in flight.
    en = 1'b1; rsp_ready = 1'b0;
    send(32'd10, 32'd1, 32'd0, 4'd1);
    wait_valid("rst_fill", lat);
    send(32'd10, 32'd2, 32'd0, 4'd2);
    send(32'd10, 32'd3, 32'd0, 4'd3);
    rst = 1'b1;
    #1;
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", req_ready, 0);
    chk("midrst_data", rsp_data, 0);
    chk("midrst_alu_a", alu_a, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    rsp_ready = 1'b1;
    acc = 0;
    for (int c = 0; c < 12; c++) begin
      if (rsp_valid) acc++;
      step();
    end
    chk("midrst_no_stale", acc, 0);
    send(32'd20, 32'd22, 32'd0, 4'd5);
    wait_valid("post_rst", lat);
    chk("post_rst_lat", lat, 4);
    chk("post_rst_data", rsp_data, 42);
    chk("post_rst_tag", rsp_tag, 5);
    chk("post_rst_err", rsp_err, 0);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
